// File: rtl/Purple_Jade_pkg.sv
// Shared store-buffer types: per-entry record and the LSU writeback bundle.
// Default widths here set the defaults of store_buffer's parameters.
package Purple_Jade_pkg;

  localparam int SB_ENTRY  = 8;
  localparam int WORD_SIZE = 16;
  localparam int SB_IDX_W  = $clog2(SB_ENTRY);

  typedef struct packed {
    logic                 valid;
    logic                 resolved;
    logic                 committed;
    logic [WORD_SIZE-1:0] address;
    logic [WORD_SIZE-1:0] data;
  } sb_entry_t;

  typedef struct packed {
    logic [SB_IDX_W-1:0]  sb_dest;
    logic [WORD_SIZE-1:0] address;
    logic [WORD_SIZE-1:0] result;
  } CDB_sb_t;

endpackage

// File: rtl/sb_bypass_sel.sv
// Load bypass select: among entries older than the load tag (walking from head),
// picks the youngest available entry whose address matches.
module sb_bypass_sel #(
  parameter  int SB_ENTRY_P  = 8,
  parameter  int WORD_SIZE_P = 16,
  localparam int IDX_W       = $clog2(SB_ENTRY_P)
) (
  input  logic [SB_ENTRY_P-1:0]                  avail_i,
  input  logic [SB_ENTRY_P-1:0][WORD_SIZE_P-1:0] addr_i,
  input  logic [SB_ENTRY_P-1:0][WORD_SIZE_P-1:0] data_i,
  input  logic [IDX_W-1:0]                       head_i,
  input  logic [IDX_W-1:0]                       tag_i,
  input  logic [WORD_SIZE_P-1:0]                 ld_addr_i,
  output logic                                   hit_o,
  output logic [WORD_SIZE_P-1:0]                 value_o
);

  logic [IDX_W-1:0] idx;
  logic             older;

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    older   = 1'b1;
    idx     = head_i;
    for (int i = 0; i < SB_ENTRY_P; i++) begin
      idx = head_i + IDX_W'(i);
      if (idx == tag_i) older = 1'b0;
      if (older && avail_i[idx] && (addr_i[idx] == ld_addr_i)) begin
        hit_o   = 1'b1;
        value_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer (head <= commit <= tail) with in-order memory drain.
// Optional load bypass enabled by macro SB_LD_BYPASS_EN.
module store_buffer
  import Purple_Jade_pkg::*;
#(
  parameter  int SB_ENTRY_P   = SB_ENTRY,
  parameter  int WORD_SIZE_P  = WORD_SIZE,
  localparam int IDX_W        = $clog2(SB_ENTRY_P),
  localparam int CDB_SB_WIDTH = IDX_W + 2 * WORD_SIZE_P
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    alloc_v_i,
  output logic                    alloc_ready_o,
  output logic [IDX_W-1:0]        alloc_sb_num_o,
  input  logic                    lsu_sb_v_i,
  input  logic [CDB_SB_WIDTH-1:0] lsu_sb_i,
  input  logic                    commit_v_i,
  input  logic [WORD_SIZE_P-1:0]  exe_ld_bypass_addr_i,
  input  logic [IDX_W-1:0]        exe_ld_bypass_sb_num_i,
  output logic                    sb_ld_bypass_valid_o,
  output logic [WORD_SIZE_P-1:0]  sb_ld_bypass_value_o,
  output logic                    mem_w_v_o,
  output logic [WORD_SIZE_P-1:0]  mem_w_addr_o,
  output logic [WORD_SIZE_P-1:0]  mem_w_data_o,
  input  logic                    mem_w_ready_i,
  input  logic                    misprediction_i
);

  logic [IDX_W-1:0] head_q, head_d, commit_q, commit_d, tail_q, tail_d;
  logic [SB_ENTRY_P-1:0] valid_q, valid_d, resolved_q, resolved_d, committed_q, committed_d;
  logic [SB_ENTRY_P-1:0][WORD_SIZE_P-1:0] addr_q, addr_d, data_q, data_d;

  logic [IDX_W-1:0]       lsu_dest;
  logic [WORD_SIZE_P-1:0] lsu_addr, lsu_data;
  logic                   full, head_ready, drain;

  assign lsu_dest = lsu_sb_i[CDB_SB_WIDTH-1 -: IDX_W];
  assign lsu_addr = lsu_sb_i[2*WORD_SIZE_P-1 -: WORD_SIZE_P];
  assign lsu_data = lsu_sb_i[WORD_SIZE_P-1:0];

  // Full is judged on registered pointers only; a drain this cycle frees nothing yet.
  assign full       = (tail_q + IDX_W'(1)) == head_q;
  assign head_ready = valid_q[head_q] & committed_q[head_q] & resolved_q[head_q];
  assign drain      = head_ready & mem_w_ready_i;

  assign alloc_ready_o  = reset_i | ~full;
  assign alloc_sb_num_o = reset_i ? '0 : tail_q;
  assign mem_w_v_o      = ~reset_i & head_ready;
  assign mem_w_addr_o   = addr_q[head_q];
  assign mem_w_data_o   = data_q[head_q];

  always_comb begin
    head_d      = head_q;
    commit_d    = commit_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    resolved_d  = resolved_q;
    committed_d = committed_q;
    addr_d      = addr_q;
    data_d      = data_q;

    if (commit_v_i) begin
      committed_d[commit_q] = 1'b1;
      commit_d              = commit_q + IDX_W'(1);
    end

    if (misprediction_i) begin
      // Everything younger than the (post-commit) commit pointer is squashed.
      tail_d = commit_d;
      for (int i = 0; i < SB_ENTRY_P; i++) begin
        if (!committed_d[i]) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
    end else begin
      if (lsu_sb_v_i && valid_q[lsu_dest]) begin
        addr_d[lsu_dest]     = lsu_addr;
        data_d[lsu_dest]     = lsu_data;
        resolved_d[lsu_dest] = 1'b1;
      end
      if (alloc_v_i && !full) begin
        valid_d[tail_q]     = 1'b1;
        resolved_d[tail_q]  = 1'b0;
        committed_d[tail_q] = 1'b0;
        tail_d              = tail_q + IDX_W'(1);
      end
    end

    if (drain) begin
      valid_d[head_q]     = 1'b0;
      resolved_d[head_q]  = 1'b0;
      committed_d[head_q] = 1'b0;
      head_d              = head_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q      <= '0;
      commit_q    <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      resolved_q  <= '0;
      committed_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      head_q      <= head_d;
      commit_q    <= commit_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      committed_q <= committed_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

`ifdef SB_LD_BYPASS_EN
  logic                   byp_hit;
  logic [WORD_SIZE_P-1:0] byp_value;

  sb_bypass_sel #(
    .SB_ENTRY_P  (SB_ENTRY_P),
    .WORD_SIZE_P (WORD_SIZE_P)
  ) u_bypass_sel (
    .avail_i   (valid_q & resolved_q),
    .addr_i    (addr_q),
    .data_i    (data_q),
    .head_i    (head_q),
    .tag_i     (exe_ld_bypass_sb_num_i),
    .ld_addr_i (exe_ld_bypass_addr_i),
    .hit_o     (byp_hit),
    .value_o   (byp_value)
  );

  assign sb_ld_bypass_valid_o = ~reset_i & byp_hit;
  assign sb_ld_bypass_value_o = (~reset_i & byp_hit) ? byp_value : '0;
`else
  logic unused_bypass;
  assign unused_bypass        = ^{exe_ld_bypass_addr_i, exe_ld_bypass_sb_num_i};
  assign sb_ld_bypass_valid_o = 1'b0;
  assign sb_ld_bypass_value_o = '0;
`endif

  // Commit must target an allocated, already-resolved store.
  commit_legal_a: assert property (@(posedge clk_i) disable iff (reset_i)
    commit_v_i |-> ((commit_q != tail_q) && resolved_q[commit_q]));

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;
  import Purple_Jade_pkg::*;

`ifdef SB_LD_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        alloc_v_i = 1'b0;
  logic        alloc_ready_o;
  logic [2:0]  alloc_sb_num_o;
  logic        lsu_sb_v_i = 1'b0;
  logic [34:0] lsu_sb_i = '0;
  logic        commit_v_i = 1'b0;
  logic [15:0] exe_ld_bypass_addr_i = '0;
  logic [2:0]  exe_ld_bypass_sb_num_i = '0;
  logic        sb_ld_bypass_valid_o;
  logic [15:0] sb_ld_bypass_value_o;
  logic        mem_w_v_o;
  logic [15:0] mem_w_addr_o, mem_w_data_o;
  logic        mem_w_ready_i = 1'b0;
  logic        misprediction_i = 1'b0;

  int checks = 0;
  int failures = 0;

  store_buffer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o), .alloc_sb_num_o(alloc_sb_num_o),
    .lsu_sb_v_i(lsu_sb_v_i), .lsu_sb_i(lsu_sb_i), .commit_v_i(commit_v_i),
    .exe_ld_bypass_addr_i(exe_ld_bypass_addr_i), .exe_ld_bypass_sb_num_i(exe_ld_bypass_sb_num_i),
    .sb_ld_bypass_valid_o(sb_ld_bypass_valid_o), .sb_ld_bypass_value_o(sb_ld_bypass_value_o),
    .mem_w_v_o(mem_w_v_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
    .mem_w_ready_i(mem_w_ready_i), .misprediction_i(misprediction_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: in-flight stores in age order, oldest at index 0.
  typedef struct {
    bit          res;
    bit          com;
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t sbq[$];
  int   m_head = 0;

  function automatic int n_com();
    int n = 0;
    foreach (sbq[i]) if (sbq[i].com) n++;
    return n;
  endfunction

  function automatic int pos_of(int idx);
    return (idx - m_head) & 7;
  endfunction

  function automatic bit head_ready();
    return (sbq.size() > 0) && sbq[0].com && sbq[0].res;
  endfunction

  task automatic model_bypass(input int tag, input logic [15:0] addr,
                              output bit hit, output logic [15:0] val);
    int n;
    hit = 1'b0;
    val = '0;
    n = pos_of(tag);
    for (int p = 0; p < n; p++) begin
      if (p < sbq.size() && sbq[p].res && sbq[p].a == addr) begin
        hit = 1'b1;
        val = sbq[p].d;
      end
    end
  endtask

  always @(posedge clk_i) begin
    bit   drain;
    int   p;
    ent_t e;
    if (reset_i) begin
      sbq.delete();
      m_head = 0;
    end else begin
      drain = head_ready() && mem_w_ready_i;
      if (commit_v_i) begin
        p = n_com();
        if (p < sbq.size()) begin
          e = sbq[p]; e.com = 1'b1; sbq[p] = e;
        end
      end
      if (misprediction_i) begin
        while (sbq.size() > 0 && !sbq[sbq.size()-1].com) sbq.pop_back();
      end else begin
        if (lsu_sb_v_i) begin
          p = pos_of(int'(lsu_sb_i[34:32]));
          if (p < sbq.size()) begin
            e = sbq[p]; e.a = lsu_sb_i[31:16]; e.d = lsu_sb_i[15:0]; e.res = 1'b1; sbq[p] = e;
          end
        end
        if (alloc_v_i && sbq.size() < 7) begin
          e.res = 1'b0; e.com = 1'b0; e.a = '0; e.d = '0;
          sbq.push_back(e);
        end
      end
      if (drain) begin
        void'(sbq.pop_front());
        m_head = (m_head + 1) & 7;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    bit          e_ready, e_mv, e_bv;
    logic [2:0]  e_num;
    logic [15:0] e_bval;
    if (reset_i) begin
      e_ready = 1'b1; e_num = '0; e_mv = 1'b0; e_bv = 1'b0; e_bval = '0;
    end else begin
      e_ready = sbq.size() < 7;
      e_num   = 3'((m_head + sbq.size()) & 7);
      e_mv    = head_ready();
      model_bypass(int'(exe_ld_bypass_sb_num_i), exe_ld_bypass_addr_i, e_bv, e_bval);
      if (!BYP_EN) begin e_bv = 1'b0; e_bval = '0; end
      if (e_mv) begin
        chk("mdl_mem_addr", mem_w_addr_o, sbq[0].a);
        chk("mdl_mem_data", mem_w_data_o, sbq[0].d);
      end
    end
    chk("mdl_alloc_ready", alloc_ready_o, e_ready);
    chk("mdl_alloc_num", alloc_sb_num_o, e_num);
    chk("mdl_mem_v", mem_w_v_o, e_mv);
    chk("mdl_byp_valid", sb_ld_bypass_valid_o, e_bv);
    chk("mdl_byp_value", sb_ld_bypass_value_o, e_bval);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    alloc_v_i = 1'b0; lsu_sb_v_i = 1'b0; commit_v_i = 1'b0; misprediction_i = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; tick(); tick(); reset_i = 1'b0;
  endtask

  task automatic do_alloc();
    alloc_v_i = 1'b1; tick();
  endtask

  task automatic do_resolve(input int dest, input logic [15:0] a, input logic [15:0] d);
    CDB_sb_t c;
    c.sb_dest = 3'(dest); c.address = a; c.result = d;
    lsu_sb_i = c; lsu_sb_v_i = 1'b1; tick();
  endtask

  task automatic do_commit();
    commit_v_i = 1'b1; tick();
  endtask

  task automatic lookup(input int tag, input logic [15:0] a);
    exe_ld_bypass_sb_num_i = 3'(tag); exe_ld_bypass_addr_i = a;
  endtask

  function automatic logic [15:0] byp(input logic [15:0] v);
    return BYP_EN ? v : 16'h0;
  endfunction

  initial begin
    // Reset behaviour
    lookup(1, 16'h0040);
    settle();
    chk("rst_ready", alloc_ready_o, 1);
    chk("rst_num", alloc_sb_num_o, 0);
    chk("rst_mem_v", mem_w_v_o, 0);
    chk("rst_byp_v", sb_ld_bypass_valid_o, 0);
    do_reset();

    // Fill
    for (int i = 0; i < 7; i++) do_alloc();
    settle();
    chk("fill_ready", alloc_ready_o, 0);
    chk("fill_num", alloc_sb_num_o, 7);
    do_alloc();
    settle();
    chk("fill_extra_num", alloc_sb_num_o, 7);

    // Bypass and age
    do_resolve(0, 16'h0040, 16'h1111);
    do_resolve(1, 16'h0040, 16'h2222);
    do_resolve(3, 16'h0080, 16'h3333);
    lookup(2, 16'h0040); settle();
    chk("byp_tag2_v", sb_ld_bypass_valid_o, BYP_EN);
    chk("byp_tag2_val", sb_ld_bypass_value_o, byp(16'h2222));
    lookup(1, 16'h0040); settle();
    chk("byp_tag1_val", sb_ld_bypass_value_o, byp(16'h1111));
    lookup(3, 16'h0080); settle();
    chk("age_tag3_v", sb_ld_bypass_valid_o, 0);
    lookup(4, 16'h0080); settle();
    chk("age_tag4_val", sb_ld_bypass_value_o, byp(16'h3333));
    lookup(0, 16'h0040); settle();
    chk("byp_head_v", sb_ld_bypass_valid_o, 0);

    // Drain with backpressure
    do_commit();
    settle();
    chk("drain_v", mem_w_v_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("drain_hold_v", mem_w_v_o, 1);
      chk("drain_hold_addr", mem_w_addr_o, 16'h0040);
      chk("drain_hold_data", mem_w_data_o, 16'h1111);
    end
    mem_w_ready_i = 1'b1; tick(); mem_w_ready_i = 1'b0;
    lookup(2, 16'h0040); settle();
    chk("drain_done_v", mem_w_v_o, 0);
    chk("drain_ready", alloc_ready_o, 1);
    chk("drain_head1_val", sb_ld_bypass_value_o, byp(16'h2222));
    lookup(1, 16'h0040); settle();
    chk("drain_head1_empty", sb_ld_bypass_valid_o, 0);

    // Flush
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc();
    for (int i = 0; i < 4; i++) do_resolve(i, 16'h0050 + 16'(i), 16'hB000 + 16'(i));
    do_commit();
    misprediction_i = 1'b1; tick();
    settle();
    chk("flush_tail", alloc_sb_num_o, 1);
    do_resolve(2, 16'h0052, 16'hDEAD);
    lookup(4, 16'h0052); settle();
    chk("flush_inv_v", sb_ld_bypass_valid_o, 0);
    chk("flush_keep_v", mem_w_v_o, 1);
    chk("flush_keep_addr", mem_w_addr_o, 16'h0050);
    mem_w_ready_i = 1'b1; tick(); mem_w_ready_i = 1'b0;
    settle();
    chk("flush_drained", mem_w_v_o, 0);
    chk("flush_num_after", alloc_sb_num_o, 1);

    // Wrap
    do_reset();
    mem_w_ready_i = 1'b1;
    for (int i = 0; i < 22; i++) begin
      do_alloc();
      do_resolve(i % 8, 16'h0100 + 16'(i), 16'hC000 + 16'(i));
      do_commit();
      tick();
    end
    mem_w_ready_i = 1'b0;
    settle();
    chk("wrap_num", alloc_sb_num_o, 6);
    for (int i = 0; i < 3; i++) do_alloc();
    do_resolve(6, 16'h0200, 16'hA006);
    do_resolve(7, 16'h0200, 16'hA007);
    do_resolve(0, 16'h0200, 16'hA000);
    settle();
    chk("wrap_num2", alloc_sb_num_o, 1);
    lookup(1, 16'h0200); settle();
    chk("wrap_tag1_val", sb_ld_bypass_value_o, byp(16'hA000));
    lookup(0, 16'h0200); settle();
    chk("wrap_tag0_val", sb_ld_bypass_value_o, byp(16'hA007));
    lookup(7, 16'h0200); settle();
    chk("wrap_tag7_val", sb_ld_bypass_value_o, byp(16'hA006));
    lookup(6, 16'h0200); settle();
    chk("wrap_tag6_v", sb_ld_bypass_valid_o, 0);

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int      dest, p, nc;
      CDB_sb_t c;
      reset_i         = ($urandom_range(0, 499) == 0);
      alloc_v_i       = $urandom_range(0, 1) == 1;
      misprediction_i = ($urandom_range(0, 31) == 0);
      mem_w_ready_i   = $urandom_range(0, 2) != 0;
      dest = $urandom_range(0, 7);
      p    = pos_of(dest);
      c.sb_dest = 3'(dest);
      c.address = 16'h0010 + 16'($urandom_range(0, 3));
      c.result  = 16'($urandom);
      lsu_sb_i   = c;
      lsu_sb_v_i = ($urandom_range(0, 1) == 1) && !(p < sbq.size() && sbq[p].res);
      nc = n_com();
      commit_v_i = ($urandom_range(0, 2) == 0) && nc < sbq.size() && sbq[nc].res;
      lookup($urandom_range(0, 7), 16'h0010 + 16'($urandom_range(0, 3)));
      @(posedge clk_i);
      #1;
    end
    reset_i = 1'b0; alloc_v_i = 1'b0; lsu_sb_v_i = 1'b0; commit_v_i = 1'b0; misprediction_i = 1'b0;
    tick();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
